// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Dual fetch is enabled by defining IFETCH_DUAL_EN (see ifetch_unit).
package ifetch_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int IMEM_AW    = 6;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

  // Byte addresses are forced onto a word boundary before use as a fetch PC
  function automatic logic [DATA_WIDTH-1:0] align_pc(input logic [DATA_WIDTH-1:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch-unit bus: instruction memory read ports, redirect request and decode handshake.
interface ifetch_if;
  import ifetch_pkg::*;

  logic [IMEM_AW-1:0]    imem_a1;
  logic [IMEM_AW-1:0]    imem_a2;
  logic [DATA_WIDTH-1:0] imem_rd1;
  logic [DATA_WIDTH-1:0] imem_rd2;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [DATA_WIDTH-1:0] out_pc;

  modport master (
    output imem_a1, imem_a2,
    input  imem_rd1, imem_rd2,
    input  redirect_valid, redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr, out_pc
  );

  modport slave (
    input  imem_a1, imem_a2,
    output imem_rd1, imem_rd2,
    output redirect_valid, redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr, out_pc
  );

endinterface

// File: rtl/ifetch_buf.sv
// Circular instruction buffer: up to two pushes and one pop per cycle, plus flush.
module ifetch_buf
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             push_cnt,
  input  fetch_entry_t           push0,
  input  fetch_entry_t           push1,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_p1;

  assign wr_ptr_p1 = wr_ptr + 1'b1;
  assign head      = mem[rd_ptr];

  // Storage needs no reset: the head is only exposed while count is nonzero
  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) mem[wr_ptr]    <= push0;
    if (push_cnt == 2'd2) mem[wr_ptr_p1] <= push1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_cnt);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(push_cnt) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit feeding decode through a small buffer.
// Define IFETCH_DUAL_EN to fetch two words per cycle; otherwise one.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  ifetch_if.master bus
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [CNT_W-1:0]      count;
  logic [CNT_W:0]        free;
  logic                  transfer;
  logic [1:0]            push_cnt;
  fetch_entry_t          head;
  fetch_entry_t          push0;
  fetch_entry_t          push1;

  assign transfer = bus.out_valid && bus.out_ready;
  assign free     = (CNT_W+1)'(BUF_DEPTH) - {1'b0, count} + (CNT_W+1)'(transfer);

  assign bus.imem_a1 = fetch_pc[IMEM_AW+1:2];
`ifdef IFETCH_DUAL_EN
  assign bus.imem_a2 = bus.imem_a1 + 1'b1;
`else
  assign bus.imem_a2 = bus.imem_a1;
`endif

  assign push0 = '{pc: fetch_pc,          instr: bus.imem_rd1};
  assign push1 = '{pc: fetch_pc + 32'd4,  instr: bus.imem_rd2};

  // A redirect flushes the buffer, so nothing fetched this cycle may be kept
  always_comb begin
    push_cnt = 2'd0;
    if (!bus.redirect_valid) begin
`ifdef IFETCH_DUAL_EN
      if (free >= (CNT_W+1)'(2))      push_cnt = 2'd2;
      else if (free == (CNT_W+1)'(1)) push_cnt = 2'd1;
`else
      if (free != '0)                 push_cnt = 2'd1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  fetch_pc <= align_pc(RESET_PC);
    else if (bus.redirect_valid) fetch_pc <= align_pc(bus.redirect_pc);
    else                         fetch_pc <= fetch_pc + 32'({push_cnt, 2'b00});
  end

  ifetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_cnt (push_cnt),
    .push0    (push0),
    .push1    (push1),
    .pop      (transfer),
    .flush    (bus.redirect_valid),
    .head     (head),
    .count    (count)
  );

  // With an empty buffer the outputs show registered fetch state, never memory data
  assign bus.out_valid = (count != '0);
  assign bus.out_instr = bus.out_valid ? head.instr : '0;
  assign bus.out_pc    = bus.out_valid ? head.pc    : fetch_pc;

endmodule
